div_share_sched: RTL
====================

# div_share_sched

Schedules one shared AXI-Stream divider among NUM_CH compressor gain calculators. Each calculator presents a (target energy, measured energy) pair. The block arbitrates round-robin and issues each pair to the divider's dividend/divisor channels. It tags every issued request in order and returns each quotient on one result stream, with the originating channel number in `m_res_tdest`. It sits between the per-channel energy/threshold calculators and the gain-apply stage.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- AXI_DATA_WIDTH, 32, dividend/divisor width
- RES_WIDTH, 64, divider result width
- MAX_INFLIGHT, 8, tag FIFO depth (power of 2); maximum requests outstanding in the divider

Ports:
- aclk  in  1  clock; all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- s_req_a_tdata  in  NUM_CH*AXI_DATA_WIDTH  packed per-channel dividend (channel k at slice k)
- s_req_b_tdata  in  NUM_CH*AXI_DATA_WIDTH  packed per-channel divisor
- s_req_tvalid  in  NUM_CH  per-channel request valid (a and b travel together)
- s_req_tready  out  NUM_CH  per-channel request accept
- m_div_dividend_tdata / _tvalid / _tready  out/out/in  AXI_DATA_WIDTH/1/1  divider dividend channel
- m_div_divisor_tdata / _tvalid / _tready  out/out/in  AXI_DATA_WIDTH/1/1  divider divisor channel
- s_div_dout_tdata / _tvalid / _tready  in/in/out  RES_WIDTH/1/1  divider result
- m_res_tdata  out  RES_WIDTH  quotient
- m_res_tdest  out  $clog2(NUM_CH)  originating channel
- m_res_tvalid / m_res_tready  out/in  1/1  result handshake
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding tag count
- err_orphan  out  1  sticky: divider result arrived with no outstanding tag

## Operation
- Issue stage: two holding registers, one for dividend and one for divisor, each with its own valid bit. Each valid bit clears independently on its own tready handshake.
- Grant condition: both issue valids clear (or clearing this cycle) and inflight < MAX_INFLIGHT. Otherwise all s_req_tready are 0.
- Arbiter: round-robin, starting from the channel after the last granted one; after reset the first priority is channel 0. At most one grant per cycle. s_req_tready is one-hot, or all zero.
- On grant: load both issue registers, set both valids, push the channel id onto the tag FIFO.
- Result stage: one output register. s_div_dout_tready = !m_res_tvalid || m_res_tready.
  - On a dout handshake: pop the tag, load m_res_tdata and m_res_tdest, set m_res_tvalid.
  - m_res_tvalid clears on a m_res_tready handshake when no new result is loaded that cycle.
- Push and pop may occur in the same cycle: inflight is unchanged. A push is gated only by inflight < MAX_INFLIGHT, registered, so a same-cycle pop does not free a slot early.
- Orphan: a dout handshake with an empty tag FIFO sets err_orphan. That result is dropped, and s_div_dout_tready stays 1 for it.
- FSM for the issue stage: IDLE (both clear) → ISSUE (either valid set) → IDLE when both are accepted.

## Timing
- Reset values: s_req_tready 0, all m_*_tvalid 0, all tdata 0, m_res_tdest 0, inflight 0, err_orphan 0, RR pointer to channel 0.
- Reset mid-operation clears all state. Results for requests issued before reset then arrive as orphans and set err_orphan.
- Request accept → dividend/divisor tvalid: 1 cycle.
- Divider dout handshake → m_res_tvalid: 1 cycle.
- With m_res_tready held 1, sustained throughput is one result per cycle.

## Configuration
- DIV_ZERO_GUARD_EN defined:
  - A granted request with divisor == 0 is not issued to the divider. Its tag is pushed with a zero flag.
  - When a flagged tag reaches the FIFO head and the output register can load, the block emits all-ones m_res_tdata with that channel as m_res_tdest, without waiting for the divider. s_div_dout_tready is 0 in that cycle.
  - Result order is preserved.
- DIV_ZERO_GUARD_EN undefined: divisor 0 is forwarded like any other value, and no zero flag bit exists in the FIFO.

## Structure
- Shared package `comp_pkg`:
  - CH_W = $clog2(NUM_CH)
  - tag_t struct: channel id, plus the zero flag when guarded
  - all-ones saturation constant
- Sub-module `div_tag_fifo`: synchronous FIFO of tag_t with push, pop, count, full and empty outputs.

## Test plan
- Single request: ch1 sends a=1000, b=10; divider returns 100 after 20 cycles → m_res_tdata=100, m_res_tdest=1, inflight back to 0.
- Contention: ch0 and ch1 both valid for 4 cycles, divider always ready → grants go ch0, ch1, ch0, ch1, and results return in the same order with matching tdest.
- Backpressure: dividend tready held 0 for 5 cycles while divisor tready is 1 → divisor accepted once, no new grant until dividend is accepted, no duplicate issue.
- Full: divider never returns; 8 requests accepted → inflight=8 and all s_req_tready 0. One result returns → the next grant happens one cycle later.
- Orphan and reset: reset asserted with 3 requests in flight, then the divider returns 3 results → all dropped, err_orphan=1, m_res_tvalid stays 0.
- DIV_ZERO_GUARD_EN: ch0 sends b=0 behind an in-flight ch1 request → ch1's quotient is emitted first, then all-ones with tdest 0; the divider sees exactly one request.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types for the divider-sharing scheduler.
// Optional feature: define DIV_ZERO_GUARD_EN to add a zero-divisor flag to each tag.
package comp_pkg;

    // Tags are sized for the largest supported channel count (8), so every
    // instance shares one tag_t; the top truncates to $clog2(NUM_CH) on output.
    localparam int NUM_CH_MAX = 8;
    localparam int CH_W       = $clog2(NUM_CH_MAX);

    // All-ones saturation value, sliced to the result width by the user.
    localparam int RES_W_MAX = 128;
    localparam logic [RES_W_MAX-1:0] SAT_ONES = '1;

`ifdef DIV_ZERO_GUARD_EN
    typedef struct packed {
        logic            zero;
        logic [CH_W-1:0] ch;
    } tag_t;
`else
    typedef struct packed {
        logic [CH_W-1:0] ch;
    } tag_t;
`endif

endpackage

// File: rtl/div_tag_fifo.sv
// In-order tag FIFO: one entry per request outstanding in the divider.
// DEPTH must be a power of two (pointers wrap naturally), and at least 2.
module div_tag_fifo
    import comp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push,
    input  tag_t                   push_tag,
    input  logic                   pop,
    output tag_t                   head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one AXI-Stream divider among NUM_CH requesters.
// Requests are tagged in issue order; quotients come back on m_res with the
// originating channel in m_res_tdest.
// Optional feature: DIV_ZERO_GUARD_EN answers divisor==0 with all-ones locally.
module div_share_sched
    import comp_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int RES_WIDTH      = 64,
    parameter int MAX_INFLIGHT   = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_CH*AXI_DATA_WIDTH-1:0] s_req_a_tdata,
    input  logic [NUM_CH*AXI_DATA_WIDTH-1:0] s_req_b_tdata,
    input  logic [NUM_CH-1:0]                s_req_tvalid,
    output logic [NUM_CH-1:0]                s_req_tready,
    output logic [AXI_DATA_WIDTH-1:0]        m_div_dividend_tdata,
    output logic                             m_div_dividend_tvalid,
    input  logic                             m_div_dividend_tready,
    output logic [AXI_DATA_WIDTH-1:0]        m_div_divisor_tdata,
    output logic                             m_div_divisor_tvalid,
    input  logic                             m_div_divisor_tready,
    input  logic [RES_WIDTH-1:0]             s_div_dout_tdata,
    input  logic                             s_div_dout_tvalid,
    output logic                             s_div_dout_tready,
    output logic [RES_WIDTH-1:0]             m_res_tdata,
    output logic [$clog2(NUM_CH)-1:0]        m_res_tdest,
    output logic                             m_res_tvalid,
    input  logic                             m_res_tready,
    output logic [$clog2(MAX_INFLIGHT):0]    inflight,
    output logic                             err_orphan
);
    localparam int TD_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    typedef enum logic {IDLE, ISSUE} iss_state_t;

    iss_state_t                state;
    logic                      run_q;
    logic [TD_W-1:0]           rr_ptr;
    logic [TD_W-1:0]           gnt_idx;
    logic                      gnt_any;
    logic                      gnt;
    logic                      issue_clear;
    logic                      iss_load;
    logic                      a_vld_nxt;
    logic                      b_vld_nxt;
    logic [AXI_DATA_WIDTH-1:0] gnt_a;
    logic [AXI_DATA_WIDTH-1:0] gnt_b;
    tag_t                      push_tag;
    tag_t                      head;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;
    logic                      pop;
    logic                      out_ld_ok;
    logic                      dout_hs;
    logic                      zero_emit;

    // Issue stage can take a new pair when both holding registers are empty
    // or draining this cycle; full is registered, so a same-cycle pop never
    // frees a slot early.
    assign issue_clear = (state == IDLE) ||
                         ((!m_div_dividend_tvalid || m_div_dividend_tready) &&
                          (!m_div_divisor_tvalid  || m_div_divisor_tready));
    assign gnt   = run_q && issue_clear && !full && gnt_any;
    assign gnt_a = s_req_a_tdata[gnt_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign gnt_b = s_req_b_tdata[gnt_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];

    // Round-robin search starting at rr_ptr; first valid channel wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && s_req_tvalid[(int'(rr_ptr) + i) % NUM_CH]) begin
                gnt_any = 1'b1;
                gnt_idx = TD_W'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
    end

    // One-hot accept for the granted channel only.
    always_comb begin
        s_req_tready = '0;
        if (gnt) s_req_tready[gnt_idx] = 1'b1;
    end

    // Tag contents and whether the divider actually sees this request.
    always_comb begin
        push_tag    = '0;
        push_tag.ch = CH_W'(gnt_idx);
`ifdef DIV_ZERO_GUARD_EN
        push_tag.zero = (gnt_b == '0);
        iss_load      = gnt && (gnt_b != '0);
`else
        iss_load      = gnt;
`endif
    end

    // Next state of the two independent issue valids.
    always_comb begin
        a_vld_nxt = m_div_dividend_tvalid && !m_div_dividend_tready;
        b_vld_nxt = m_div_divisor_tvalid  && !m_div_divisor_tready;
        if (iss_load) begin
            a_vld_nxt = 1'b1;
            b_vld_nxt = 1'b1;
        end
    end

    // Issue FSM with registered dividend/divisor outputs; run_q holds off
    // grants until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                 <= IDLE;
            run_q                 <= 1'b0;
            m_div_dividend_tvalid <= 1'b0;
            m_div_divisor_tvalid  <= 1'b0;
            m_div_dividend_tdata  <= '0;
            m_div_divisor_tdata   <= '0;
        end else begin
            run_q                 <= 1'b1;
            m_div_dividend_tvalid <= a_vld_nxt;
            m_div_divisor_tvalid  <= b_vld_nxt;
            state                 <= (a_vld_nxt || b_vld_nxt) ? ISSUE : IDLE;
            if (iss_load) begin
                m_div_dividend_tdata <= gnt_a;
                m_div_divisor_tdata  <= gnt_b;
            end
        end
    end

    // Round-robin pointer advances past the channel just granted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  rr_ptr <= '0;
        else if (gnt)  rr_ptr <= (gnt_idx == TD_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
    end

    div_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (gnt),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign inflight  = count;
    assign out_ld_ok = !m_res_tvalid || m_res_tready;

`ifdef DIV_ZERO_GUARD_EN
    // A zero-flagged head is answered locally, so the divider is held off.
    assign zero_emit         = !empty && head.zero && out_ld_ok;
    assign s_div_dout_tready = (out_ld_ok && !(!empty && head.zero)) || empty;
`else
    assign zero_emit         = 1'b0;
    assign s_div_dout_tready = out_ld_ok || empty;
`endif

    // Results with no tag (e.g. issued before a reset) are always swallowed.
    assign dout_hs = s_div_dout_tvalid && s_div_dout_tready;
    assign pop     = (dout_hs && !empty) || zero_emit;

    // Result register and sticky orphan flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_res_tvalid <= 1'b0;
            m_res_tdata  <= '0;
            m_res_tdest  <= '0;
            err_orphan   <= 1'b0;
        end else begin
            if (dout_hs && empty) err_orphan <= 1'b1;
            if (dout_hs && !empty) begin
                m_res_tvalid <= 1'b1;
                m_res_tdata  <= s_div_dout_tdata;
                m_res_tdest  <= TD_W'(head.ch);
            end else if (zero_emit) begin
                m_res_tvalid <= 1'b1;
                m_res_tdata  <= SAT_ONES[RES_WIDTH-1:0];
                m_res_tdest  <= TD_W'(head.ch);
            end else if (m_res_tready) begin
                m_res_tvalid <= 1'b0;
            end
        end
    end

endmodule
